// File: rtl/dram_lsu_if.sv
// rtl/dram_lsu_if.sv - CPU-side request/response bundle for the DRAM load/store unit
interface dram_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dram_lsu.sv
// rtl/dram_lsu.sv - RV32I load/store unit driving a synchronous single-port DRAM
// Byte/half/word lane steering on writes, lane select and extension on reads.
module dram_lsu #(
  parameter int ADDR_BITS = 16
) (
  input  logic                 clka,
  input  logic                 rst_n,
  dram_lsu_if.slave            lsu,
  output logic [ADDR_BITS-1:0] dram_addra,
  output logic [3:0]           dram_wea,
  output logic [31:0]          dram_dina,
  input  logic [31:0]          dram_douta
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        accept;
  logic        req_illegal;
  logic        req_misaligned;
  logic        req_err;
  logic [1:0]  req_lane;
  logic [3:0]  wea_lanes;
  logic        we_q;
  logic        err_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_result;

  assign req_lane   = lsu.req_addr[1:0];
  assign dram_addra = lsu.req_addr[ADDR_BITS+1:2];
  assign accept     = (state_q == ST_IDLE) && lsu.req_valid;

  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    wea_lanes      = 4'b0000;
    dram_dina      = lsu.req_wdata;
    if (lsu.req_we) begin
      req_illegal = (lsu.req_funct3 > 3'd2);
    end else begin
      req_illegal = (lsu.req_funct3 == 3'b011) || (lsu.req_funct3[2:1] == 2'b11);
    end
    // funct3[1:0] encodes the access size for both loads and stores
    case (lsu.req_funct3[1:0])
      2'b00: begin
        req_misaligned = 1'b0;
        wea_lanes      = 4'b0001 << req_lane;
        dram_dina      = {4{lsu.req_wdata[7:0]}};
      end
      2'b01: begin
        req_misaligned = req_lane[0];
        wea_lanes      = 4'b0011 << req_lane;
        dram_dina      = {2{lsu.req_wdata[15:0]}};
      end
      default: begin
        req_misaligned = (req_lane != 2'b00);
        wea_lanes      = 4'b1111;
      end
    endcase
    req_err = req_illegal || req_misaligned;
  end

  // Write strobes are gated by rst_n so a reset never lets a store slip into DRAM
  assign dram_wea = (rst_n && accept && lsu.req_we && !req_err) ? wea_lanes : 4'b0000;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    lsu.req_ready = 1'b0;
    lsu.rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        lsu.req_ready = 1'b1;
        if (lsu.req_valid) begin
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        lsu.rsp_valid = 1'b1;
        if (lsu.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    byte_sel = dram_douta[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? dram_douta[31:16] : dram_douta[15:0];
    case (funct3_q)
      3'b000:  load_result = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_result = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_result = dram_douta;
      3'b100:  load_result = {24'h000000, byte_sel};
      3'b101:  load_result = {16'h0000, half_sel};
      default: load_result = 32'h0000_0000;
    endcase
    if (we_q || err_q) begin
      load_result = 32'h0000_0000;
    end
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      funct3_q      <= 3'b000;
      lane_q        <= 2'b00;
      lsu.rsp_rdata <= 32'h0000_0000;
      lsu.rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q     <= lsu.req_we;
        err_q    <= req_err;
        funct3_q <= lsu.req_funct3;
        lane_q   <= req_lane;
      end
      if (state_q == ST_READ) begin
        lsu.rsp_rdata <= load_result;
        lsu.rsp_err   <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_dram_lsu.sv
// tb/tb_dram_lsu.sv - self-checking bench for dram_lsu with a behavioural DRAM and byte-level reference
module tb_dram_lsu;
  logic        clka = 1'b0;
  logic        rst_n;
  logic [15:0] dram_addra;
  logic [3:0]  dram_wea;
  logic [31:0] dram_dina;
  logic [31:0] dram_douta;
  int          checks = 0;
  int          errors = 0;

  dram_lsu_if ifc ();

  dram_lsu #(.ADDR_BITS(16)) dut (
    .clka       (clka),
    .rst_n      (rst_n),
    .lsu        (ifc),
    .dram_addra (dram_addra),
    .dram_wea   (dram_wea),
    .dram_dina  (dram_dina),
    .dram_douta (dram_douta)
  );

  always #5 clka = ~clka;

  logic [31:0] dram_mem [0:65535];
  always @(posedge clka) begin
    for (int j = 0; j < 4; j++) begin
      if (dram_wea[j]) dram_mem[dram_addra][8*j +: 8] <= dram_dina[8*j +: 8];
    end
    dram_douta <= dram_mem[dram_addra];
  end

  logic [7:0] ref_mem [int unsigned];

  function automatic logic [7:0] ref_byte(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic void ref_txn(input logic we, input logic [2:0] f, input logic [31:0] addr,
                                  input logic [31:0] wdata, output logic [31:0] rdata,
                                  output logic err, output logic [3:0] wea, output logic [31:0] dina);
    int unsigned base, size;
    logic [31:0] v;
    base = addr & 32'h0003_FFFF;
    size = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    err  = (we ? (f > 3'd2) : (f == 3'd3 || f == 3'd6 || f == 3'd7)) || (base % size != 0);
    rdata = 32'h0;
    wea   = 4'h0;
    for (int j = 0; j < 4; j++) dina[8*j +: 8] = wdata[8*(j % size) +: 8];
    if (err) return;
    if (we) begin
      for (int i = 0; i < size; i++) ref_mem[base + i] = wdata[8*i +: 8];
      wea = 4'(((1 << size) - 1) << (base % 4));
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_byte(base + i)) << (8 * i));
      if (!f[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
      rdata = v;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Entered just after a falling edge; returns just after a falling edge in IDLE.
  task automatic txn(input logic we, input logic [2:0] f, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold,
                     output logic [31:0] rdata, output logic err, output logic [3:0] wea0,
                     output logic [31:0] dina0, output logic [15:0] addra0,
                     output int lat, output logic [3:0] wea_late);
    ifc.req_we = we; ifc.req_funct3 = f; ifc.req_addr = addr; ifc.req_wdata = wdata;
    ifc.req_valid = 1'b1;
    #1;
    wea0 = dram_wea; dina0 = dram_dina; addra0 = dram_addra;
    chk("req_ready_idle", 32'(ifc.req_ready), 32'd1);
    @(posedge clka);
    lat = 0; wea_late = 4'h0; rdata = 32'h0; err = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clka);
      ifc.req_valid = 1'b0;
      #1;
      wea_late = wea_late | dram_wea;
      if (ifc.rsp_valid) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    rdata = ifc.rsp_rdata;
    err   = ifc.rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clka);
      ifc.req_valid = 1'b1; ifc.req_we = 1'b1; ifc.req_funct3 = 3'b010; ifc.req_wdata = 32'hFFFF_FFFF;
      #1;
      chk("hold_valid", 32'(ifc.rsp_valid), 32'd1);
      chk("hold_rdata", ifc.rsp_rdata, rdata);
      chk("hold_err", 32'(ifc.rsp_err), 32'(err));
      chk("hold_req_ready", 32'(ifc.req_ready), 32'd0);
      chk("hold_wea", 32'(dram_wea), 32'd0);
    end
    ifc.req_valid = 1'b0;
    ifc.rsp_ready = 1'b1;
    @(posedge clka);
    @(negedge clka);
    ifc.rsp_ready = 1'b0;
    #1;
    chk("rsp_drop", 32'(ifc.rsp_valid), 32'd0);
    chk("ready_back", 32'(ifc.req_ready), 32'd1);
  endtask

  task automatic run(input string nm, input logic we, input logic [2:0] f, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold,
                     output logic [31:0] rdata, output logic err, output logic [3:0] wea0,
                     output logic [31:0] dina0);
    logic [31:0] e_rdata, e_dina;
    logic        e_err;
    logic [3:0]  e_wea, wea_late;
    logic [15:0] addra0;
    int          lat;
    ref_txn(we, f, addr, wdata, e_rdata, e_err, e_wea, e_dina);
    txn(we, f, addr, wdata, hold, rdata, err, wea0, dina0, addra0, lat, wea_late);
    chk({nm, "_rdata"}, rdata, e_rdata);
    chk({nm, "_err"}, 32'(err), 32'(e_err));
    chk({nm, "_wea"}, 32'(wea0), 32'(e_wea));
    if (e_wea != 4'h0) chk({nm, "_dina"}, dina0, e_dina);
    chk({nm, "_addra"}, 32'(addra0), (addr >> 2) & 32'h0000_FFFF);
    chk({nm, "_latency"}, 32'(lat), 32'd2);
    chk({nm, "_wea_late"}, 32'(wea_late), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wea;
    logic [31:0] dina;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, di, a, wd;
    logic        er, we;
    logic [3:0]  wa;
    logic [2:0]  f;

    tbl[0]  = '{1'b0, 3'b000, 32'h0000_1003, 32'h0, 4'h0, 32'h0, 32'hFFFF_FF80, 1'b0};
    tbl[1]  = '{1'b0, 3'b100, 32'h0000_1003, 32'h0, 4'h0, 32'h0, 32'h0000_0080, 1'b0};
    tbl[2]  = '{1'b0, 3'b101, 32'h0000_1002, 32'h0, 4'h0, 32'h0, 32'h0000_80FF, 1'b0};
    tbl[3]  = '{1'b0, 3'b001, 32'h0000_1000, 32'h0, 4'h0, 32'h0, 32'h0000_1234, 1'b0};
    tbl[4]  = '{1'b0, 3'b010, 32'h0000_1000, 32'h0, 4'h0, 32'h0, 32'h80FF_1234, 1'b0};
    tbl[5]  = '{1'b0, 3'b001, 32'h0000_1002, 32'h0, 4'h0, 32'h0, 32'hFFFF_80FF, 1'b0};
    tbl[6]  = '{1'b0, 3'b000, 32'h0000_1001, 32'h0, 4'h0, 32'h0, 32'h0000_0012, 1'b0};
    tbl[7]  = '{1'b0, 3'b010, 32'h0000_1001, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1};
    tbl[8]  = '{1'b1, 3'b001, 32'h0000_1003, 32'h0000_1234, 4'h0, 32'h0, 32'h0, 1'b1};
    tbl[9]  = '{1'b0, 3'b011, 32'h0000_1000, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1};
    tbl[10] = '{1'b1, 3'b100, 32'h0000_1000, 32'h5555_5555, 4'h0, 32'h0, 32'h0, 1'b1};
    tbl[11] = '{1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 32'h0, 1'b0};
    tbl[12] = '{1'b0, 3'b010, 32'h0000_1000, 32'h0, 4'h0, 32'h0, 32'hABFF_1234, 1'b0};
    tbl[13] = '{1'b0, 3'b001, 32'hFFFC_1000, 32'h0, 4'h0, 32'h0, 32'h0000_1234, 1'b0};
    tbl[14] = '{1'b1, 3'b001, 32'h0000_1002, 32'hCAFE_5678, 4'b1100, 32'h5678_5678, 32'h0, 1'b0};
    tbl[15] = '{1'b0, 3'b010, 32'h0000_1000, 32'h0, 4'h0, 32'h0, 32'h5678_1234, 1'b0};

    rst_n = 1'b0;
    ifc.req_valid = 1'b0; ifc.req_we = 1'b0; ifc.req_funct3 = 3'b000;
    ifc.req_addr = 32'h0; ifc.req_wdata = 32'h0; ifc.rsp_ready = 1'b0;
    repeat (3) @(posedge clka);
    @(negedge clka);
    #1;
    chk("reset_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
    chk("reset_rsp_rdata", ifc.rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(ifc.rsp_err), 32'd0);
    chk("reset_wea", 32'(dram_wea), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("reset_req_ready", 32'(ifc.req_ready), 32'd1);

    // Seed the region used by the table and random phases through the design itself
    for (int i = 0; i < 16; i++) begin
      wd = (i == 0) ? 32'h80FF_1234 : $urandom;
      run("init", 1'b1, 3'b010, 32'h0000_1000 + 32'(4 * i), wd, 0, rd, er, wa, di);
    end

    for (int i = 0; i < 16; i++) begin
      run($sformatf("tbl%0d", i), tbl[i].we, tbl[i].f, tbl[i].addr, tbl[i].wdata, 0, rd, er, wa, di);
      chk($sformatf("tbl%0d_const_rdata", i), rd, tbl[i].rdata);
      chk($sformatf("tbl%0d_const_err", i), 32'(er), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_const_wea", i), 32'(wa), 32'(tbl[i].wea));
      if (tbl[i].wea != 4'h0) chk($sformatf("tbl%0d_const_dina", i), di, tbl[i].dina);
    end

    run("b2b_sw", 1'b1, 3'b010, 32'h0000_2000, 32'hDEAD_BEEF, 0, rd, er, wa, di);
    run("b2b_lw", 1'b0, 3'b010, 32'h0000_2000, 32'h0, 0, rd, er, wa, di);
    chk("b2b_const_rdata", rd, 32'hDEAD_BEEF);

    run("hold_lw", 1'b0, 3'b010, 32'h0000_1000, 32'h0, 3, rd, er, wa, di);
    chk("hold_const_rdata", rd, 32'h5678_1234);
    run("hold_after", 1'b0, 3'b010, 32'h0000_1000, 32'h0, 0, rd, er, wa, di);
    chk("hold_after_const", rd, 32'h5678_1234);

    // Reset while the load is in its READ cycle, with a store waiting on the bus
    ifc.req_we = 1'b0; ifc.req_funct3 = 3'b010; ifc.req_addr = 32'h0000_1000; ifc.req_valid = 1'b1;
    @(posedge clka);
    @(negedge clka);
    ifc.req_we = 1'b1; ifc.req_wdata = 32'h1111_1111;
    #1;
    chk("rst_pre_valid", 32'(ifc.rsp_valid), 32'd0);
    chk("rst_pre_rdata", ifc.rsp_rdata, 32'h5678_1234);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(ifc.rsp_valid), 32'd0);
    chk("rst_mid_rdata", ifc.rsp_rdata, 32'd0);
    chk("rst_mid_err", 32'(ifc.rsp_err), 32'd0);
    chk("rst_mid_wea", 32'(dram_wea), 32'd0);
    @(posedge clka);
    @(negedge clka);
    ifc.req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ready", 32'(ifc.req_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clka);
      #1;
      chk("rst_no_rsp", 32'(ifc.rsp_valid), 32'd0);
    end
    run("rst_after", 1'b0, 3'b010, 32'h0000_1000, 32'h0, 0, rd, er, wa, di);
    chk("rst_after_const", rd, 32'h5678_1234);

    for (int n = 0; n < 80; n++) begin
      we = 1'($urandom_range(0, 1));
      f  = 3'($urandom_range(0, 7));
      a  = ($urandom & 32'hFFFC_0000) | (32'h0000_1000 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3)));
      run($sformatf("rnd%0d", n), we, f, a, $urandom, $urandom_range(0, 2), rd, er, wa, di);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
